m4x2_encoder_sync: RTL and testbench
====================================

# m4x2_encoder_sync

Registered 4-to-2 encoder with handshake: the receive-side counterpart of the team's 2x4 active-low decoder. It samples four active-low one-cold select lines, synchronises them, encodes the asserted line back into the (B,A) code that drives the decoder, and presents the result with a valid/ready handshake. It sits between asynchronous select sources (push buttons, decoder outputs from another domain) and synchronous consumers.

## Interface
- No parameters; the width is fixed at 4 inputs and a 2-bit code.
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `D`  input  4  active-low select lines, asynchronous to `clk`
- `E`  input  1  active-high disable, same polarity as the decoder's `E`; 1 masks `D` as all-high
- `R`  input  1  consumer ready
- `A`  output  1  code bit 0
- `B`  output  1  code bit 1
- `V`  output  1  code valid
- `ERR`  output  1  more than one `D` line was low in the captured sample; qualified by `V`

## Operation
- Code map, the exact inverse of the decoder: `D[3]` low gives (B,A)=(0,0); `D[2]` gives (1,0); `D[1]` gives (0,1); `D[0]` gives (1,1).
- Input path:
  - Two-flop synchroniser on `D`; both stages reset to 4'b1111.
  - Masked sample `S` = `E_sync` ? 4'b1111 : sync2. `E` gets its own two-flop synchroniser, reset value 1.
- Priority when several lines are low: `D[3]` > `D[2]` > `D[1]` > `D[0]`. `ERR` = popcount of low bits in `S` > 1.
- FSM states: IDLE, HOLD, RELEASE.
  - IDLE: if `S` != 4'b1111, register A/B/ERR, set `V`=1, go to HOLD.
  - HOLD: `V`=1, and A/B/ERR stay frozen regardless of `D` or `E`.
    - On `V`&&`R`: clear `V` and `ERR`. Go to IDLE if `S`==4'b1111 in that cycle, else go to RELEASE.
  - RELEASE: `V`=0. Wait until `S`==4'b1111, then go to IDLE. There is no re-capture until all lines return high, which gives one event per press.
- A/B keep their last value after the handshake; consumers use only `V`.
- `E` rising during HOLD does not withdraw `V`. A valid word, once offered, is always delivered.

## Timing
- Reset values:
  - `A`=0, `B`=0, `V`=0, `ERR`=0.
  - Synchroniser stages 4'b1111 (`D`) and 1 (`E`).
  - State IDLE.
  - Reset takes effect immediately and asynchronously, including mid-HOLD; the pending word is lost.
- Latency: `D` stable low before rising edge k gives `V`=1 after edge k+2, i.e. three edges from input to output.
- Handshake:
  - Transfer occurs on a rising edge with `V`=1 and `R`=1.
  - `V` is low after that edge.
  - `R` held high with no event causes nothing.
  - `R` may be high before `V` rises; the transfer then completes on the first edge with `V`=1, so `V` stays high exactly one cycle.
- Minimum spacing between two events: the release must be seen (2 sync cycles + 1 FSM cycle) before the next capture.
- `D` glitches shorter than one clock may be missed; debouncing is out of scope.

## Structure
- Shared package `dec_enc_pkg`:
  - Code constants: `CODE_D3`=2'b00, `CODE_D2`=2'b10, `CODE_D1`=2'b01, `CODE_D0`=2'b11.
  - `IDLE_LINES`=4'b1111.
  - FSM state enum.
- Sub-module `sync2`: a generic two-flop synchroniser with a reset-value input, instantiated for `D` (width 4) and `E` (width 1).
- The priority encode and popcount are combinational in the top module; the FSM and output registers also sit in the top module.

## Test plan
- Reset: assert `rst_n`=0 with `D`=4'b0111 → `A`=`B`=`V`=`ERR`=0. Release reset → `V`=1 with (B,A)=(0,0) exactly three edges later.
- Each line alone: drive `D`=1011, 1101, 1110 with `R`=1 → codes (1,0), (0,1), (1,1), each with a one-cycle `V` pulse and `ERR`=0. Cross-check by feeding the code into the 2x4 decoder with `E`=0 and comparing its output to `D`.
- Priority/ERR: `D`=4'b0101 → (B,A)=(0,0), `ERR`=1. Hold `R`=0 for 10 cycles → `V`, A, B and `ERR` stay stable. Then `R`=1 → `V` and `ERR` clear after one edge.
- Release gating: hold `D`=1110 after the handshake → no second `V`. Drive `D`=1111 for 4 cycles, then 1110 again → exactly one new `V`.
- Enable: `E`=1 with `D`=0000 → no `V` ever. Raise `E` during HOLD → `V` is held until `R`, and the code is unchanged.
- Async reset mid-HOLD: `V`=1 and `rst_n` pulsed low between edges → `V`=0 immediately. After release, with `D`=1111, `V` stays 0.

Source files
------------

// File: rtl/dec_enc_pkg.sv
// Shared codes, idle pattern and FSM states for the 2x4 decoder / 4x2 encoder pair.
// Codes are (B,A) packed as {B, A}.
package dec_enc_pkg;

  localparam logic [1:0] CODE_D3 = 2'b00;
  localparam logic [1:0] CODE_D2 = 2'b10;
  localparam logic [1:0] CODE_D1 = 2'b01;
  localparam logic [1:0] CODE_D0 = 2'b11;

  localparam logic [3:0] IDLE_LINES = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/m4x2_encoder_sync_sync2.sv
// Generic two-flop synchroniser; reset loads rst_val_i into both stages.
// Latency two clk edges; no backpressure.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/m4x2_encoder_sync.sv
// Registered 4-to-2 encoder of active-low one-cold select lines with a valid/ready handshake.
// Three edges from stable D to V; V holds until R and one event is produced per press.
module m4x2_encoder_sync
  import dec_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D,
  input  logic       E,
  input  logic       R,
  output logic       A,
  output logic       B,
  output logic       V,
  output logic       ERR
);

  logic [3:0] d_sync;
  logic       e_sync;
  logic [3:0] s;
  logic       s_idle;
  logic [1:0] code;
  logic [2:0] low_cnt;
  logic       multi_low;

  enc_state_e state_q, state_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       v_q, v_d;
  logic       err_q, err_d;

  sync2 #(.W(4)) u_sync_d (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_val_i (IDLE_LINES),
    .d_i       (D),
    .q_o       (d_sync)
  );

  sync2 #(.W(1)) u_sync_e (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_val_i (1'b1),
    .d_i       (E),
    .q_o       (e_sync)
  );

  assign s      = e_sync ? IDLE_LINES : d_sync;
  assign s_idle = (s == IDLE_LINES);

  // Highest-numbered low line wins, matching the decoder's code map.
  always_comb begin
    code = CODE_D0;
    if (!s[3])      code = CODE_D3;
    else if (!s[2]) code = CODE_D2;
    else if (!s[1]) code = CODE_D1;
    else            code = CODE_D0;
  end

  always_comb begin
    low_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      low_cnt = low_cnt + {2'b00, ~s[i]};
    end
  end

  assign multi_low = (low_cnt > 3'd1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (!s_idle) begin
          b_d     = code[1];
          a_d     = code[0];
          err_d   = multi_low;
          v_d     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Word is frozen here; E or D changes cannot withdraw it.
        if (v_q && R) begin
          v_d     = 1'b0;
          err_d   = 1'b0;
          state_d = s_idle ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        v_d = 1'b0;
        if (s_idle) state_d = IDLE;
      end
      default: begin
        v_d     = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  assign A   = a_q;
  assign B   = b_q;
  assign V   = v_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_m4x2_encoder_sync.sv
// Scoreboard bench for m4x2_encoder_sync: expected words queued at stimulus time,
// popped and compared on each handshake transfer.
module tb_m4x2_encoder_sync;

  typedef struct {
    logic       b;
    logic       a;
    logic       err;
    logic [3:0] d;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic       E;
  logic       R;
  logic       A;
  logic       B;
  logic       V;
  logic       ERR;

  int   n_tests;
  int   n_fail;
  int   v_events;
  int   v_run;
  logic pulse_mode;
  exp_t exp_q[$];

  m4x2_encoder_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .E     (E),
    .R     (R),
    .A     (A),
    .B     (B),
    .V     (V),
    .ERR   (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Decoder reference: code (B,A) drives one active-low line.
  function automatic logic [3:0] dec2x4(input logic b, input logic a);
    logic [3:0] y;
    y = 4'b1111;
    case ({b, a})
      2'b00: y[3] = 1'b0;
      2'b10: y[2] = 1'b0;
      2'b01: y[1] = 1'b0;
      default: y[0] = 1'b0;
    endcase
    return y;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic a, input logic err, input logic [3:0] d);
    exp_t e;
    e.b = b; e.a = a; e.err = err; e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever V and R are both high here.
  always @(negedge clk) begin
    exp_t e;
    if (V) begin
      if (v_run == 0) v_events++;
      v_run++;
    end else begin
      if (v_run > 0 && pulse_mode) chk("v_pulse_width", v_run, 1);
      v_run = 0;
    end
    if (rst_n && V && R) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_v", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("code_ba", {B, A}, {e.b, e.a});
        chk("err", ERR, e.err);
        if (!e.err) chk("decoder_xcheck", dec2x4(B, A), e.d);
      end
    end
  end

  logic [3:0] single_pats [3];
  logic [1:0] single_codes[3];
  int         ev0;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    v_events   = 0;
    v_run      = 0;
    pulse_mode = 1'b0;
    rst_n      = 1'b1;
    D          = 4'b0111;
    E          = 1'b0;
    R          = 1'b0;
    single_pats  = '{4'b1011, 4'b1101, 4'b1110};
    single_codes = '{2'b10, 2'b01, 2'b11};

    // Reset with D[3] already low.
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_a", A, 0);
    chk("rst_b", B, 0);
    chk("rst_v", V, 0);
    chk("rst_err", ERR, 0);
    push(1'b0, 1'b0, 1'b0, 4'b0111);
    rst_n = 1'b1;
    step(2);
    chk("latency_v_edge2", V, 0);
    step(1);
    chk("latency_v_edge3", V, 1);
    chk("latency_ba", {B, A}, 2'b00);
    R = 1'b1;
    step(1);
    chk("v_after_xfer", V, 0);
    D = 4'b1111;
    step(5);

    // Each line alone, R held high ahead of V.
    pulse_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(single_codes[i][1], single_codes[i][0], 1'b0, single_pats[i]);
      D = single_pats[i];
      step(6);
      D = 4'b1111;
      step(5);
      chk("single_drain", exp_q.size(), 0);
    end
    pulse_mode = 1'b0;

    // Priority and ERR with consumer stall.
    R = 1'b0;
    push(1'b0, 1'b0, 1'b1, 4'b0101);
    D = 4'b0101;
    step(3);
    for (int i = 0; i < 10; i++) begin
      chk("stall_stable_vbaerr", {V, B, A, ERR}, 4'b1001);
      step(1);
    end
    R = 1'b1;
    step(1);
    chk("stall_v_clear", V, 0);
    chk("stall_err_clear", ERR, 0);
    D = 4'b1111;
    step(5);

    // Release gating: one event per press.
    ev0 = v_events;
    push(1'b1, 1'b1, 1'b0, 4'b1110);
    D = 4'b1110;
    step(12);
    chk("gate_one_event", v_events - ev0, 1);
    D = 4'b1111;
    step(4);
    push(1'b1, 1'b1, 1'b0, 4'b1110);
    D = 4'b1110;
    step(8);
    chk("gate_second_event", v_events - ev0, 2);
    chk("gate_drain", exp_q.size(), 0);
    D = 4'b1111;
    step(5);

    // Disable masks all lines.
    ev0 = v_events;
    E = 1'b1;
    D = 4'b0000;
    step(12);
    chk("enable_no_v", v_events - ev0, 0);
    D = 4'b1111;
    E = 1'b0;
    step(5);

    // E rising during HOLD keeps the word.
    R = 1'b0;
    push(1'b1, 1'b0, 1'b0, 4'b1011);
    D = 4'b1011;
    step(3);
    chk("hold_v", V, 1);
    E = 1'b1;
    step(5);
    chk("hold_e_vba", {V, B, A}, 3'b110);
    R = 1'b1;
    step(1);
    chk("hold_e_xfer", V, 0);
    chk("hold_e_drain", exp_q.size(), 0);
    E = 1'b0;
    D = 4'b1111;
    step(5);

    // Async reset mid-HOLD drops the pending word.
    R = 1'b0;
    push(1'b0, 1'b1, 1'b0, 4'b1101);
    D = 4'b1101;
    step(3);
    chk("arst_pre_v", V, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v_immediate", V, 0);
    chk("arst_ba", {B, A}, 2'b00);
    exp_q.delete();
    D = 4'b1111;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("arst_post_v", V, 0);
    end
    chk("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
